// File: rtl/downcounter_pkg.sv
// Shared definitions for the loadable down-counter/timer: FSM encodings and default width.
package downcounter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/downcounter_sync.sv
// Loadable down-counter/timer: a start pulse loads a value, which counts down to zero and ends in a one-cycle done pulse.
// Optional periodic mode is enabled with `define DOWNCOUNTER_SYNC_AUTORELOAD_EN.
module downcounter_sync
  import downcounter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
);

  // Handshake: start is accepted only in IDLE and stop only in RUN; both are
  // single-cycle level samples on the rising edge, with no ready/ack returned.
  state_t state;

`ifdef DOWNCOUNTER_SYNC_AUTORELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  assign dbg_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef DOWNCOUNTER_SYNC_AUTORELOAD_EN
      reload <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            count  <= load_value;
`ifdef DOWNCOUNTER_SYNC_AUTORELOAD_EN
            reload <= load_value;
`endif
            if (load_value != '0) begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end else begin
              state <= ST_DONE;
              done  <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (enable && count != '0) begin
            count <= count - WIDTH'(1);
            // Reaching zero on this edge: the done pulse occupies the next cycle.
            if (count == WIDTH'(1)) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          done <= 1'b0;
`ifdef DOWNCOUNTER_SYNC_AUTORELOAD_EN
          if (reload != '0) begin
            state <= ST_RUN;
            count <= reload;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
`else
          state <= ST_IDLE;
          busy  <= 1'b0;
`endif
        end

        default: begin
          // Unused encoding: fall back to IDLE without disturbing count.
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/downcounter_sync.md
Name: downcounter_sync

Overview:
- Synchronous loadable down-counter/timer; the counting-down counterpart to the team's free-running synchronous up-counter.
- Started by a pulse, counts a programmed value down to zero, then signals completion with a one-cycle done pulse.
- Used as an interval/timeout generator beside the up-counter in the same single-clock domain.

Parameters:
- WIDTH, 4, bit width of load_value and count.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset==0 resets immediately, regardless of clock).
- start  input  1  begin a count from load_value; sampled only in IDLE.
- load_value  input  WIDTH  start value, captured on an accepted start.
- enable  input  1  count-advance qualifier; decrement only when 1.
- stop  input  1  abort the current count; sampled only in RUN.
- count  output  WIDTH  current counter value (registered).
- busy  output  1  1 while in RUN (registered).
- done  output  1  one-cycle pulse in DONE (registered).

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, count=0, busy=0, done=0, reload register=0. Outputs hold these values until the first rising edge after reset returns high.
- Reset asserted mid-count aborts immediately: no done pulse, and count=0.
- FSM states: IDLE=0, RUN=1, DONE=2. Encoding 3 is illegal and recovers to IDLE on the next edge.
- IDLE:
  - count holds its last value, busy=0, done=0.
  - start==1 at edge N: count<=load_value, reload<=load_value.
  - If load_value!=0, go to RUN, so busy=1 from edge N.
  - If load_value==0, go directly to DONE, with count=0.
- RUN:
  - Priority is stop > enable.
  - stop==1: go to IDLE, count holds, busy drops at that edge, and no done pulse.
  - Otherwise, enable==1: count<=count-1.
  - If count==1 and enable==1: count<=0 and next state is DONE.
  - enable==0: count and state hold.
  - start is ignored in RUN.
- DONE:
  - done=1 and busy=0 for exactly one cycle; count=0.
  - Next state is IDLE (but see Optional Feature).
  - start and stop are ignored in DONE.
- Latency: with enable held high, start at edge N with value L≥1 gives count=L at N, 0 at N+L, done=1 during the cycle after edge N+L, and IDLE from edge N+L+1.
- Arithmetic: count never decrements below 0 and never wraps; a decrement occurs only in RUN with count≥1.
- load_value is sampled only at an accepted start; later changes have no effect on a count in progress.

Optional Feature:
- Macro: DOWNCOUNTER_SYNC_AUTORELOAD_EN.
- Defined:
  - DONE goes to RUN with count<=reload when reload!=0, giving a periodic done pulse every reload+1 cycles under constant enable.
  - busy stays 0 only during the DONE cycle.
  - stop in RUN still returns to IDLE.
  - If reload==0, DONE goes to IDLE.
- Undefined: DONE always goes to IDLE, and the reload register may be optimised away. Port list is identical in both cases.

Decomposition:
- Shared package/include downcounter_pkg: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the default WIDTH constant.
- No sub-module is natural. FSM and datapath stay in one module; the datapath is a single register with decrement.

Test Plan:
- Reset: hold reset=0 for 20 ns with start=1 -> count=0, busy=0, done=0 throughout; release, then no activity until start is sampled in IDLE.
- Basic count: load_value=5, start pulse, enable=1 -> count 5,4,3,2,1,0 on successive edges, done=1 for exactly one cycle, then IDLE; busy high for 5 cycles.
- Gating and stop: load_value=9, enable toggled 1/0 each cycle -> decrement only on enabled edges; stop=1 with count=4 -> IDLE, count stays 4, no done pulse.
- Boundaries:
  - load_value=0 -> DONE on the next edge with count=0 and one done pulse, no RUN cycle.
  - load_value=15 (max) -> 15 decrements with no wrap.
  - start during RUN and DONE -> ignored.
- Async reset mid-operation: assert reset=0 between clock edges while count=6 -> outputs go to 0 immediately without waiting for an edge, and no done pulse follows.
- With DOWNCOUNTER_SYNC_AUTORELOAD_EN defined: load_value=3, enable=1 -> done pulses every 4 cycles repeatedly until stop=1.
